// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: EX/MEM register, word-organised synchronous data memory, MEM/WB register.
// Define MEM_BYTE_ACCESS_EN to add byte/halfword loads and stores (sizeE, loadUnsignedE).
module memory_access_stage #(
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallM,
    input  logic        flushM,
    input  logic        regWriteE,
    input  logic        memToRegE,
    input  logic        memReadE,
    input  logic        memWriteE,
    input  logic [31:0] AluOutE,
    input  logic [31:0] writeDataE,
    input  logic [4:0]  writeRegE,
`ifdef MEM_BYTE_ACCESS_EN
    input  logic [1:0]  sizeE,
    input  logic        loadUnsignedE,
`endif
    output logic        regWriteM,
    output logic [4:0]  writeRegM,
    output logic [31:0] AluOutM,
    output logic        misalignM,
    output logic        regWriteW,
    output logic [4:0]  writeRegW,
    output logic [31:0] resultW
);

    logic                 memToRegM, memReadM, memWriteM;
    logic [31:0]          writeDataM;
    logic                 memToRegW;
    logic [31:0]          AluOutW, readDataW;
    logic [31:0]          mem [DEPTH];
    logic [ADDR_BITS-1:0] idxM;
    logic                 mem_we;
    logic [3:0]           lane_mask;
    logic [31:0]          store_data, load_data;
`ifdef MEM_BYTE_ACCESS_EN
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    logic [1:0]  sizeM, sizeW;
    logic        loadUnsignedM, loadUnsignedW;
    logic [31:0] shifted;
`endif

    // Word index ignores the upper address bits, so accesses wrap modulo DEPTH*4.
    assign idxM = AluOutM[ADDR_BITS+1:2];

    // EX/MEM register: stall holds, flush inserts a bubble, stall wins over flush.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst || (flushM && !stallM)) begin
            regWriteM  <= 1'b0;
            memToRegM  <= 1'b0;
            memReadM   <= 1'b0;
            memWriteM  <= 1'b0;
            AluOutM    <= '0;
            writeDataM <= '0;
            writeRegM  <= '0;
`ifdef MEM_BYTE_ACCESS_EN
            sizeM         <= '0;
            loadUnsignedM <= 1'b0;
`endif
        end else if (!stallM) begin
            regWriteM  <= regWriteE;
            memToRegM  <= memToRegE;
            memReadM   <= memReadE;
            memWriteM  <= memWriteE;
            AluOutM    <= AluOutE;
            writeDataM <= writeDataE;
            writeRegM  <= writeRegE;
`ifdef MEM_BYTE_ACCESS_EN
            sizeM         <= sizeE;
            loadUnsignedM <= loadUnsignedE;
`endif
        end
    end

    // Alignment check, lane enables and lane-replicated store data.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        misalignM  = (memReadM | memWriteM) & (AluOutM[1:0] != 2'b00);
        lane_mask  = 4'b1111;
        store_data = writeDataM;
`ifdef MEM_BYTE_ACCESS_EN
        case (sizeM)
            SZ_HALF: begin
                misalignM  = (memReadM | memWriteM) & AluOutM[0];
                lane_mask  = AluOutM[1] ? 4'b1100 : 4'b0011;
                store_data = {2{writeDataM[15:0]}};
            end
            SZ_BYTE: begin
                misalignM  = 1'b0;
                lane_mask  = 4'b0001 << AluOutM[1:0];
                store_data = {4{writeDataM[7:0]}};
            end
            default: ;
        endcase
`endif
    end

    assign mem_we = memWriteM & ~stallM & ~misalignM & ~rst;

    // NOTE: the memory array is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) mem[idxM][8*b +: 8] <= store_data[8*b +: 8];
            end
        end
    end

    // MEM/WB register; the synchronous memory read lands here when M advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            regWriteW <= 1'b0;
            memToRegW <= 1'b0;
            AluOutW   <= '0;
            writeRegW <= '0;
            readDataW <= '0;
`ifdef MEM_BYTE_ACCESS_EN
            sizeW         <= '0;
            loadUnsignedW <= 1'b0;
`endif
        end else if (!stallM) begin
            regWriteW <= regWriteM & ~misalignM;
            memToRegW <= memToRegM;
            AluOutW   <= AluOutM;
            writeRegW <= writeRegM;
            readDataW <= mem[idxM];
`ifdef MEM_BYTE_ACCESS_EN
            sizeW         <= sizeM;
            loadUnsignedW <= loadUnsignedM;
`endif
        end
    end

    // Lane extraction after the read register keeps the RAM read path plain.
    always_comb begin
        load_data = readDataW;
`ifdef MEM_BYTE_ACCESS_EN
        shifted = readDataW >> {AluOutW[1:0], 3'b000};
        case (sizeW)
            SZ_HALF: begin
                shifted   = AluOutW[1] ? {16'b0, readDataW[31:16]} : {16'b0, readDataW[15:0]};
                load_data = loadUnsignedW ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_BYTE:
                load_data = loadUnsignedW ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            default: ;
        endcase
`endif
    end

    assign resultW = memToRegW ? load_data : AluOutW;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed, table-driven bench for memory_access_stage; byte/halfword cases run when MEM_BYTE_ACCESS_EN is defined.
module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        rst, stallM, flushM, regWriteE, memToRegE, memReadE, memWriteE;
    logic [31:0] AluOutE, writeDataE;
    logic [4:0]  writeRegE;
    logic        regWriteM, misalignM, regWriteW;
    logic [4:0]  writeRegM, writeRegW;
    logic [31:0] AluOutM, resultW;
`ifdef MEM_BYTE_ACCESS_EN
    logic [1:0]  sizeE = 2'b00;
    logic        loadUnsignedE = 1'b0;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    memory_access_stage #(.DEPTH(256), .ADDR_BITS(8)) dut (
        .clk(clk), .rst(rst), .stallM(stallM), .flushM(flushM),
        .regWriteE(regWriteE), .memToRegE(memToRegE), .memReadE(memReadE), .memWriteE(memWriteE),
        .AluOutE(AluOutE), .writeDataE(writeDataE), .writeRegE(writeRegE),
`ifdef MEM_BYTE_ACCESS_EN
        .sizeE(sizeE), .loadUnsignedE(loadUnsignedE),
`endif
        .regWriteM(regWriteM), .writeRegM(writeRegM), .AluOutM(AluOutM), .misalignM(misalignM),
        .regWriteW(regWriteW), .writeRegW(writeRegW), .resultW(resultW)
    );

    typedef struct {
        logic        rst, stall, flush, rw, m2r, mr, mw;
        logic [31:0] alu, wd;
        logic [4:0]  wreg;
        logic        e_rwM;
        logic [4:0]  e_wregM;
        logic [31:0] e_aluM;
        logic        e_mis, e_rwW;
        logic [4:0]  e_wregW;
        logic [31:0] e_resW;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, s, f, rw, m2r, mr, mw,
                         input logic [31:0] alu, wd, input logic [4:0] wr);
        rst = r; stallM = s; flushM = f;
        regWriteE = rw; memToRegE = m2r; memReadE = mr; memWriteE = mw;
        AluOutE = alu; writeDataE = wd; writeRegE = wr;
    endtask

    // Drive one cycle of inputs, let the rising edge pass, return at the falling edge.
    task automatic step(input logic r, s, f, rw, m2r, mr, mw,
                        input logic [31:0] alu, wd, input logic [4:0] wr);
        drive(r, s, f, rw, m2r, mr, mw, alu, wd, wr);
        @(negedge clk);
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    endtask

    initial begin
        //         rst s f rw m2r mr mw alu           wd            wreg   rwM wregM aluM        mis rwW wregW resW
        vecs[0]  = '{1, 0, 0, 1, 1, 1, 1, $urandom(), $urandom(), 5'd31, 0, 5'd0, 32'h0,    0, 0, 5'd0, 32'h0};
        vecs[1]  = '{1, 0, 0, 1, 0, 1, 1, $urandom(), $urandom(), 5'd17, 0, 5'd0, 32'h0,    0, 0, 5'd0, 32'h0};
        vecs[2]  = '{0, 0, 0, 1, 0, 0, 0, 32'h1234, 32'h0,        5'd5,  1, 5'd5, 32'h1234, 0, 0, 5'd0, 32'h0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 1, 32'h10,   32'hDEADBEEF, 5'd0,  0, 5'd0, 32'h10,   0, 1, 5'd5, 32'h1234};
        vecs[4]  = '{0, 0, 0, 1, 1, 1, 0, 32'h10,   32'h0,        5'd8,  1, 5'd8, 32'h10,   0, 0, 5'd0, 32'h10};
        vecs[5]  = '{0, 0, 0, 1, 1, 1, 0, 32'h410,  32'h0,        5'd9,  1, 5'd9, 32'h410,  0, 1, 5'd8, 32'hDEADBEEF};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0,    32'h0,        5'd0,  0, 5'd0, 32'h0,    0, 1, 5'd9, 32'hDEADBEEF};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 1, 32'h20,   32'h5555AAAA, 5'd0,  0, 5'd0, 32'h20,   0, 0, 5'd0, 32'h0};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 1, 32'h22,   32'h11111111, 5'd0,  0, 5'd0, 32'h22,   1, 0, 5'd0, 32'h20};
        vecs[9]  = '{0, 0, 0, 1, 1, 1, 0, 32'h20,   32'h0,        5'd3,  1, 5'd3, 32'h20,   0, 0, 5'd0, 32'h22};
        vecs[10] = '{0, 0, 0, 1, 1, 1, 0, 32'h22,   32'h0,        5'd4,  1, 5'd4, 32'h22,   1, 1, 5'd3, 32'h5555AAAA};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 32'h0,    32'h0,        5'd0,  0, 5'd0, 32'h0,    0, 0, 5'd4, 32'h5555AAAA};
        vecs[12] = '{0, 0, 1, 1, 0, 0, 0, 32'h77,   32'h0,        5'd7,  0, 5'd0, 32'h0,    0, 0, 5'd0, 32'h0};
        vecs[13] = '{0, 0, 0, 1, 0, 0, 0, 32'h99,   32'h0,        5'd6,  1, 5'd6, 32'h99,   0, 0, 5'd0, 32'h0};
        vecs[14] = '{0, 1, 1, 1, 0, 0, 0, 32'hAB,   32'h0,        5'd2,  1, 5'd6, 32'h99,   0, 0, 5'd0, 32'h0};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 32'h0,    32'h0,        5'd0,  0, 5'd0, 32'h0,    0, 1, 5'd6, 32'h99};

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].rw, vecs[i].m2r,
                 vecs[i].mr, vecs[i].mw, vecs[i].alu, vecs[i].wd, vecs[i].wreg);
            check($sformatf("v%0d.regWriteM", i), regWriteM, vecs[i].e_rwM);
            check($sformatf("v%0d.writeRegM", i), writeRegM, vecs[i].e_wregM);
            check($sformatf("v%0d.AluOutM", i),   AluOutM,   vecs[i].e_aluM);
            check($sformatf("v%0d.misalignM", i), misalignM, vecs[i].e_mis);
            check($sformatf("v%0d.regWriteW", i), regWriteW, vecs[i].e_rwW);
            check($sformatf("v%0d.writeRegW", i), writeRegW, vecs[i].e_wregW);
            check($sformatf("v%0d.resultW", i),   resultW,   vecs[i].e_resW);
        end

        // Store held by a 3-cycle stall while a load waits in E; the store lands once on release.
        step(0, 0, 0, 0, 0, 0, 1, 32'h30, 32'h0BADF00D, 5'd0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 1, 1, 1, 0, 32'h30, 32'h0, 5'd10);
            check($sformatf("stall%0d.AluOutM", k),   AluOutM,   32'h30);
            check($sformatf("stall%0d.regWriteM", k), regWriteM, 1'b0);
            check($sformatf("stall%0d.regWriteW", k), regWriteW, 1'b0);
            check($sformatf("stall%0d.resultW", k),   resultW,   32'h0);
        end
        step(0, 0, 0, 1, 1, 1, 0, 32'h30, 32'h0, 5'd10);
        check("stall_rel.writeRegM", writeRegM, 5'd10);
        nop();
        check("stall_ld.regWriteW", regWriteW, 1'b1);
        check("stall_ld.resultW",   resultW,   32'h0BADF00D);

        // Reset arriving while a store sits stalled in M: memory keeps the older value.
        step(0, 0, 0, 0, 0, 0, 1, 32'h34, 32'h12345678, 5'd0);
        step(0, 0, 0, 0, 0, 0, 1, 32'h34, 32'hCAFEF00D, 5'd0);
        step(1, 1, 0, 1, 0, 0, 1, 32'h34, 32'hCAFEF00D, 5'd1);
        check("rst_stall.AluOutM",   AluOutM,   32'h0);
        check("rst_stall.misalignM", misalignM, 1'b0);
        check("rst_stall.regWriteW", regWriteW, 1'b0);
        check("rst_stall.resultW",   resultW,   32'h0);
        step(0, 0, 0, 1, 1, 1, 0, 32'h34, 32'h0, 5'd11);
        nop();
        check("rst_stall_ld.writeRegW", writeRegW, 5'd11);
        check("rst_stall_ld.resultW",   resultW,   32'h12345678);

`ifdef MEM_BYTE_ACCESS_EN
        sizeE = 2'b00; loadUnsignedE = 1'b0;
        step(0, 0, 0, 0, 0, 0, 1, 32'h40, 32'h80FF7F01, 5'd0);
        sizeE = 2'b10; loadUnsignedE = 1'b0;
        step(0, 0, 0, 1, 1, 1, 0, 32'h43, 32'h0, 5'd12);
        sizeE = 2'b10; loadUnsignedE = 1'b1;
        step(0, 0, 0, 1, 1, 1, 0, 32'h43, 32'h0, 5'd13);
        check("lb.resultW", resultW, 32'hFFFFFF80);
        sizeE = 2'b01; loadUnsignedE = 1'b0;
        step(0, 0, 0, 1, 1, 1, 0, 32'h40, 32'h0, 5'd14);
        check("lbu.resultW", resultW, 32'h00000080);
        sizeE = 2'b10; loadUnsignedE = 1'b0;
        step(0, 0, 0, 0, 0, 0, 1, 32'h41, 32'h000000AA, 5'd0);
        check("lh.resultW", resultW, 32'h00007F01);
        check("sb.misalignM", misalignM, 1'b0);
        sizeE = 2'b00; loadUnsignedE = 1'b0;
        step(0, 0, 0, 1, 1, 1, 0, 32'h40, 32'h0, 5'd15);
        nop();
        check("sb_lw.resultW", resultW, 32'h80FFAA01);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
